ram_byte_packer: RTL and testbench
==================================

Name: ram_byte_packer

Overview:
- Write-side companion to the 512x32 / 2048x8 dual-port command buffer.
- Accepts a byte stream from an 8-bit producer (valid/ready) and packs the bytes little-endian into 32-bit words.
- Drives the buffer's 32-bit write port with per-byte write enables.
- Byte n lands at word n>>2, lane n&3, so the 8-bit port later reads bytes back in stream order.

Parameters:
- ADDR_W, 9, word address width of the 32-bit port.
- BASE_ADDR, 0, first word address written after Start.
- MAX_BYTES, 2048, byte capacity before Full asserts; must be a multiple of 4 and ≤ 4*2^ADDR_W.

Ports:
- Clk  in  1  sole clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Start  in  1  pulse: clear counters and pointers, enter FILL.
- Flush  in  1  pulse: write out any partial word, then finish.
- In_data  in  8  stream byte.
- In_valid  in  1  In_data is valid.
- In_ready  out  1  block accepts a byte this cycle.
- ADDR_A  out  ADDR_W  word address to RAM.
- WD_A  out  32  write data to RAM.
- WEN_A  out  4  per-byte write enable to RAM; nonzero for exactly one cycle per write.
- Byte_count  out  12  bytes accepted since Start.
- Busy  out  1  state is not IDLE.
- Full  out  1  MAX_BYTES accepted; sticky until Start or reset.
- Done  out  1  one-cycle pulse at completion.

Behaviour:
- Reset (async, Rst_n=0) applies immediately: state IDLE; ADDR_A=BASE_ADDR; WD_A=0; WEN_A=0; Byte_count=0; In_ready=0; Busy=0; Full=0; Done=0; hold register and lane mask cleared. A write in progress is dropped.
- All outputs are registered except In_ready, which is combinational: (state==FILL) && !Full.
- A byte is accepted on a rising edge where In_valid && In_ready.
- States and transitions:
  - IDLE → FILL on Start.
  - FILL → FLUSH on Flush.
  - FLUSH → DONE after 1 cycle.
  - DONE → IDLE after 1 cycle.
- Start has priority in every state. It clears Byte_count, Full, the lane pointer, the hold register and mask, and sets the word pointer to BASE_ADDR. A partial word that has not been written is discarded. A write already presented on the outputs in that cycle still completes.
- FILL: an accepted byte is merged into hold[8*lane +: 8], mask[lane] is set, the lane increments, and Byte_count increments.
- When lane 3 is accepted, the same edge loads ADDR_A=word_ptr, WD_A=merged word and WEN_A=full mask, then clears hold and mask and increments word_ptr (wrapping mod 2^ADDR_W). The write is visible the next cycle; latency is 1 cycle from the 4th byte.
- In_ready stays high across write cycles, so back-to-back words are sustained at 1 byte per clock.
- Otherwise WEN_A returns to 0 on the following edge; WD_A and ADDR_A hold their values.
- The edge that accepts byte number MAX_BYTES sets Full, so In_ready=0 from the next cycle. The block stays in FILL waiting for Flush; later bytes are not accepted.
- Flush in FILL:
  - If a byte is accepted on the same edge, it is merged first.
  - If the resulting mask is nonzero, the same edge loads the partial write: WEN_A=mask, with unused lanes of WD_A set to 0.
  - If the mask is zero, no write is issued.
  - The block then goes to FLUSH and In_ready=0.
- Done is asserted during the DONE cycle, which is the cycle after the flush write is visible (or after the FLUSH cycle when no write was issued). It is never asserted otherwise.
- Flush in IDLE, FLUSH or DONE is ignored. Start and Flush on the same edge: Start wins.
- Byte_count does not wrap; it stops at MAX_BYTES.

Test Plan:
- Start, then bytes 11,22,33,44 on consecutive cycles → one cycle with ADDR_A=0, WD_A=0x44332211, WEN_A=4'hF; Byte_count=4; In_ready stays 1.
- Start, bytes 11..66 (6 bytes), then Flush → writes at addr 0 (WEN F, 0x44332211) and addr 1 (WEN 4'b0011, WD_A=0x00006655); Done pulses once, 2 cycles after Flush; Byte_count=6; Busy=0 afterwards.
- Flush asserted on the same edge as the 3rd byte 0xAB → single write with WEN 4'b0111 and WD_A[23:16]=0xAB.
- Continuous valid for 2048 bytes (value = index mod 256) → 512 writes, addresses 0..511, one per 4 clocks; Full=1 and In_ready=0 after the last byte; a held 2049th byte is not accepted; Flush → Done with no write.
- Pull Rst_n low mid-word, between write cycles (after 2 bytes) → all outputs reach reset values without a clock edge; WEN_A never pulses; after release and Start, the first write goes to BASE_ADDR.
- Start asserted after 5 bytes → pending byte 5 discarded, no write; the next 4 bytes are written at BASE_ADDR; Byte_count restarts at 0.

Source files
------------

// File: rtl/ram_byte_packer_if.sv
// Byte-stream handshake between an 8-bit producer (master) and the packer (slave).
interface ram_byte_packer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ram_byte_packer.sv
// Packs an 8-bit byte stream little-endian into 32-bit words and drives the
// command buffer's 32-bit write port with per-byte write enables.
module ram_byte_packer #(
  parameter int ADDR_W    = 9,
  parameter int BASE_ADDR = 0,
  parameter int MAX_BYTES = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  ram_byte_packer_if.slave  stream,
  output logic [ADDR_W-1:0] addr_a,
  output logic [31:0]       wd_a,
  output logic [3:0]        wen_a,
  output logic [11:0]       byte_count,
  output logic              busy,
  output logic              full,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_W = ADDR_W'(BASE_ADDR);
  localparam logic [11:0]       MAX_W  = 12'(MAX_BYTES);

  state_t            state_r, state_nxt_s;
  logic [31:0]       hold_r, hold_nxt_s, merged_s;
  logic [3:0]        mask_r, mask_nxt_s, mask_merged_s;
  logic [1:0]        lane_r, lane_nxt_s;
  logic [ADDR_W-1:0] word_ptr_r, word_ptr_nxt_s;
  logic              accept_s, write_s;
  logic [ADDR_W-1:0] addr_nxt_s;
  logic [31:0]       wd_nxt_s;
  logic [3:0]        wen_nxt_s;
  logic [11:0]       count_nxt_s;
  logic              full_nxt_s;

  assign stream.in_ready = (state_r == ST_FILL) && !full;

  // Byte merge, write decision and next-state for FSM and datapath.
  always_comb begin
    accept_s       = stream.in_valid && stream.in_ready && !start;
    merged_s       = hold_r;
    mask_merged_s  = mask_r;
    state_nxt_s    = state_r;
    hold_nxt_s     = hold_r;
    mask_nxt_s     = mask_r;
    lane_nxt_s     = lane_r;
    word_ptr_nxt_s = word_ptr_r;
    addr_nxt_s     = addr_a;
    wd_nxt_s       = wd_a;
    wen_nxt_s      = 4'b0000;
    count_nxt_s    = byte_count;
    full_nxt_s     = full;

    if (accept_s) begin
      merged_s[{lane_r, 3'b000} +: 8] = stream.in_data;
      mask_merged_s = mask_r | (4'b0001 << lane_r);
    end else begin
      merged_s      = hold_r;
      mask_merged_s = mask_r;
    end

    // A word is written when lane 3 lands, or when Flush finds a partial word.
    write_s = !start && (state_r == ST_FILL) &&
              ((accept_s && (lane_r == 2'd3)) || (flush && (mask_merged_s != 4'b0000)));

    if (start) begin
      state_nxt_s    = ST_FILL;
      hold_nxt_s     = 32'h0000_0000;
      mask_nxt_s     = 4'b0000;
      lane_nxt_s     = 2'd0;
      word_ptr_nxt_s = BASE_W;
      count_nxt_s    = 12'd0;
      full_nxt_s     = 1'b0;
    end else begin
      case (state_r)
        ST_FILL: begin
          if (accept_s) begin
            hold_nxt_s  = merged_s;
            mask_nxt_s  = mask_merged_s;
            lane_nxt_s  = lane_r + 2'd1;
            count_nxt_s = byte_count + 12'd1;
            full_nxt_s  = ((byte_count + 12'd1) == MAX_W);
          end else begin
            hold_nxt_s  = hold_r;
            mask_nxt_s  = mask_r;
          end
          if (write_s) begin
            addr_nxt_s     = word_ptr_r;
            wd_nxt_s       = merged_s;
            wen_nxt_s      = mask_merged_s;
            hold_nxt_s     = 32'h0000_0000;
            mask_nxt_s     = 4'b0000;
            word_ptr_nxt_s = word_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end else begin
            wen_nxt_s      = 4'b0000;
          end
          if (flush) begin
            state_nxt_s = ST_FLUSH;
          end else begin
            state_nxt_s = ST_FILL;
          end
        end
        ST_FLUSH: state_nxt_s = ST_DONE;
        ST_DONE:  state_nxt_s = ST_IDLE;
        ST_IDLE:  state_nxt_s = ST_IDLE;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and registered outputs; Busy/Done track the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r     <= 32'h0000_0000;
      mask_r     <= 4'b0000;
      lane_r     <= 2'd0;
      word_ptr_r <= BASE_W;
      addr_a     <= BASE_W;
      wd_a       <= 32'h0000_0000;
      wen_a      <= 4'b0000;
      byte_count <= 12'd0;
      full       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      hold_r     <= hold_nxt_s;
      mask_r     <= mask_nxt_s;
      lane_r     <= lane_nxt_s;
      word_ptr_r <= word_ptr_nxt_s;
      addr_a     <= addr_nxt_s;
      wd_a       <= wd_nxt_s;
      wen_a      <= wen_nxt_s;
      byte_count <= count_nxt_s;
      full       <= full_nxt_s;
      busy       <= (state_nxt_s != ST_IDLE);
      done       <= (state_nxt_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_ram_byte_packer.sv
// Bench for ram_byte_packer: table vectors, corner sequences and random traffic
// checked every cycle against a stream-level reference model.
module tb_ram_byte_packer;
  localparam int ADDR_W = 9;
  localparam int BASE   = 0;
  localparam int MAX    = 2048;

  logic              clk, rst_n, start, flush;
  logic [ADDR_W-1:0] addr_a;
  logic [31:0]       wd_a;
  logic [3:0]        wen_a;
  logic [11:0]       byte_count;
  logic              busy, full, done;

  ram_byte_packer_if s_if ();

  ram_byte_packer #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE), .MAX_BYTES(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .stream(s_if.slave),
    .addr_a(addr_a), .wd_a(wd_a), .wen_a(wen_a), .byte_count(byte_count),
    .busy(busy), .full(full), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    bit          fl_same;
    logic [7:0]  b0;
    logic [7:0]  stp;
    int          nw;
    logic [3:0]  lwen;
    logic [31:0] lwd;
    int          cnt;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wd;
    logic [3:0]        wen;
  } wr_t;

  vec_t vecs[7];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model: bytes of the current word, expected writes, status.
  bit                m_fill;
  int                m_count;
  int                m_done_in;
  logic [7:0]        m_bytes[$];
  wr_t               m_wq[$];
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wd;

  int          obs_writes, obs_done;
  logic [3:0]  obs_lwen;
  logic [31:0] obs_lwd;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fill = 1'b0; m_count = 0; m_done_in = 0;
    m_bytes.delete(); m_wq.delete();
    m_addr = ADDR_W'(BASE); m_wd = 32'h0;
  endtask

  task automatic clear_obs();
    obs_writes = 0; obs_done = 0; obs_lwen = 4'h0; obs_lwd = 32'h0;
  endtask

  // Byte k of the stream lives at word BASE + k/4; the word holds the pending bytes.
  task automatic push_write();
    wr_t w;
    w.wd = 32'h0;
    foreach (m_bytes[i]) w.wd |= 32'(m_bytes[i]) << (8 * i);
    w.wen  = 4'((1 << m_bytes.size()) - 1);
    w.addr = ADDR_W'((BASE + (m_count - 1) / 4) % (1 << ADDR_W));
    m_wq.push_back(w);
    m_bytes.delete();
  endtask

  task automatic model_edge(input logic s, input logic f, input logic v, input logic [7:0] d);
    if (!rst_n) begin
      model_reset();
    end else if (s) begin
      m_fill = 1'b1; m_count = 0; m_done_in = 0; m_bytes.delete();
    end else if (m_fill) begin
      if (v && m_count < MAX) begin
        m_bytes.push_back(d);
        m_count++;
        if (m_bytes.size() == 4) push_write();
      end
      if (f) begin
        if (m_bytes.size() > 0) push_write();
        m_fill = 1'b0;
        m_done_in = 2;
      end
    end else if (m_done_in > 0) begin
      m_done_in--;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " wen"},   32'(wen_a), 32'h0);
    check({tag, " addr"},  32'(addr_a), 32'(BASE));
    check({tag, " wd"},    wd_a, 32'h0);
    check({tag, " count"}, 32'(byte_count), 32'h0);
    check({tag, " ready"}, 32'(s_if.in_ready), 32'h0);
    check({tag, " busy"},  32'(busy), 32'h0);
    check({tag, " full"},  32'(full), 32'h0);
    check({tag, " done"},  32'(done), 32'h0);
  endtask

  // One clock: drive just after posedge, check at negedge, advance model on posedge.
  task automatic step(input logic s, input logic f, input logic v, input logic [7:0] d);
    wr_t w;
    start = s; flush = f; s_if.in_valid = v; s_if.in_data = d;
    @(negedge clk);
    check("in_ready", 32'(s_if.in_ready), 32'((m_fill && m_count < MAX) ? 1 : 0));
    check("busy", 32'(busy), 32'((m_fill || m_done_in > 0) ? 1 : 0));
    check("done", 32'(done), 32'((m_done_in == 1) ? 1 : 0));
    check("full", 32'(full), 32'((m_count == MAX) ? 1 : 0));
    check("byte_count", 32'(byte_count), 32'(m_count));
    if (m_wq.size() > 0) begin
      w = m_wq.pop_front();
      m_addr = w.addr; m_wd = w.wd;
      check("wen", 32'(wen_a), 32'(w.wen));
    end else begin
      check("wen idle", 32'(wen_a), 32'h0);
    end
    check("addr", 32'(addr_a), 32'(m_addr));
    check("wd", wd_a, m_wd);
    if (wen_a != 4'h0) begin
      obs_writes++; obs_lwen = wen_a; obs_lwd = wd_a;
    end
    if (done) obs_done++;
    @(posedge clk);
    model_edge(s, f, v, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    clear_obs();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < t.n; i++)
      step(1'b0, (t.fl_same && i == t.n - 1), 1'b1, 8'(t.b0 + 8'(i) * t.stp));
    if (!t.fl_same || t.n == 0) step(1'b0, 1'b1, 1'b0, 8'h00);
    idle(4);
    check({tag, " writes"}, 32'(obs_writes), 32'(t.nw));
    check({tag, " last wen"}, 32'(obs_lwen), 32'(t.lwen));
    check({tag, " last wd"}, obs_lwd, t.lwd);
    check({tag, " byte_count"}, 32'(byte_count), 32'(t.cnt));
    check({tag, " done pulses"}, 32'(obs_done), 32'h1);
    check({tag, " busy after"}, 32'(busy), 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4, 1'b0, 8'h11, 8'h11, 1, 4'hF, 32'h4433_2211, 4};
    vecs[1] = '{6, 1'b0, 8'h11, 8'h11, 2, 4'h3, 32'h0000_6655, 6};
    vecs[2] = '{3, 1'b1, 8'hA9, 8'h01, 1, 4'h7, 32'h00AB_AAA9, 3};
    vecs[3] = '{0, 1'b0, 8'h00, 8'h00, 0, 4'h0, 32'h0000_0000, 0};
    vecs[4] = '{1, 1'b1, 8'h5A, 8'h00, 1, 4'h1, 32'h0000_005A, 1};
    vecs[5] = '{8, 1'b1, 8'h01, 8'h01, 2, 4'hF, 32'h0807_0605, 8};
    vecs[6] = '{5, 1'b0, 8'hF0, 8'h01, 2, 4'h1, 32'h0000_00F4, 5};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    s_if.in_valid = 1'b0; s_if.in_data = 8'h00;
    model_reset(); clear_obs();
    #3;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Start after 5 bytes: pending 5th byte dropped, next word restarts at BASE.
    clear_obs();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hB1 + 8'(i)));
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check("restart count", 32'(byte_count), 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'(8'hC1 + 8'(i)));
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("restart writes", 32'(obs_writes), 32'h2);
    check("restart wd", obs_lwd, 32'hC4C3_C2C1);
    check("restart addr", 32'(addr_a), 32'(BASE));
    check("restart count4", 32'(byte_count), 32'h4);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    idle(4);

    // Async reset mid-word: outputs clear without an edge, nothing is written.
    clear_obs();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h71);
    step(1'b0, 1'b0, 1'b1, 8'h72);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async rst");
    model_reset();
    idle(2);
    rst_n = 1'b1;
    idle(1);
    check("rst no write", 32'(obs_writes), 32'h0);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h81 + 8'(i)));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    idle(4);
    check("rst first wd", obs_lwd, 32'h8483_8281);
    check("rst first addr", 32'(addr_a), 32'(BASE));

    // Fill to capacity, hold a further byte, then Flush with nothing pending.
    clear_obs();
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < MAX; i++) step(1'b0, 1'b0, 1'b1, 8'(i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'hEE);
    check("cap writes", 32'(obs_writes), 32'd512);
    check("cap last addr", 32'(addr_a), 32'd511);
    check("cap last wd", wd_a, 32'hFFFE_FDFC);
    check("cap full", 32'(full), 32'h1);
    check("cap ready", 32'(s_if.in_ready), 32'h0);
    check("cap count", 32'(byte_count), 32'd2048);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    idle(4);
    check("cap flush writes", 32'(obs_writes), 32'd512);
    check("cap done", 32'(obs_done), 32'h1);

    // Random traffic including stray Flush/Start, checked by the model.
    for (int r = 0; r < 6; r++) begin
      step(1'b1, 1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 60; i++)
        step(($urandom % 60) == 0, ($urandom % 25) == 0, ($urandom % 4) != 0, 8'($urandom));
      step(1'b0, 1'b1, 1'b0, 8'h00);
      idle(4);
    end

    check("wq drained", 32'(m_wq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
